// File: rtl/axis_uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud timing helper.
package axis_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  function automatic int tics_per_beat(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[0], d};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ff_q <= {2{RESET_VAL}};
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/axis_uart_rx.sv
// UART 8N1 receiver presenting bytes on an AXI-Stream master port, with
// frame-error and overrun pulses. Reception never waits on the downstream.
module axis_uart_rx
  import axis_uart_pkg::*;
#(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE      = 9600,
  parameter int BAUD_RATE_SIM  = 50000000
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       uart_rxd,
  output logic       rxbyte_tvalid,
  input  logic       rxbyte_tready,
  output logic [7:0] rxbyte_tdata,
  output logic       rxbyte_tkeep,
  output logic       frame_error,
  output logic       overrun
);

`ifdef SYNTHESIS
  localparam bit IS_SIM = 1'b0;
`else
  localparam bit IS_SIM = 1'b1;
`endif

  localparam int USED_BAUD_RATE = IS_SIM ? BAUD_RATE_SIM : BAUD_RATE;
  localparam int TICS_PER_BEAT  = tics_per_beat(ACLK_FREQUENCY, USED_BAUD_RATE);
  localparam int HALF_BEAT      = TICS_PER_BEAT / 2;
  localparam int CNT_W          = (TICS_PER_BEAT > 1) ? $clog2(TICS_PER_BEAT) : 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BEAT - 1);
  localparam logic [CNT_W-1:0] BEAT_LOAD = CNT_W'(TICS_PER_BEAT - 1);

  logic             rxd_s;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tvalid_q, tvalid_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             byte_done;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .aclk   (aclk),
    .aresetn(aresetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          cnt_d   = HALF_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Mid-start-bit recheck rejects short glitches on the idle line
        if (cnt_q == '0) begin
          if (!rxd_s) begin
            cnt_d   = BEAT_LOAD;
            idx_d   = 3'd0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxd_s;
          cnt_d          = BEAT_LOAD;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rxd_s) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BREAK: begin
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completing byte may replace the held one only when it is being taken
    if (tvalid_q && rxbyte_tready) begin
      tvalid_d = 1'b0;
    end
    if (byte_done) begin
      if (!tvalid_q || rxbyte_tready) begin
        tvalid_d = 1'b1;
        tdata_d  = shift_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rxbyte_tvalid = tvalid_q;
  assign rxbyte_tdata  = tdata_q;
  assign rxbyte_tkeep  = 1'b1;
  assign frame_error   = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: doc/axis_uart_rx.md
AXIS_UART_RX -- requirements
Module: axis_uart_rx

Interface
REQ-001 SHALL have parameter ACLK_FREQUENCY, default 200000000, aclk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line rate in bit/s for synthesis.
REQ-003 SHALL have parameter BAUD_RATE_SIM, default 50000000, line rate in bit/s in simulation (synthesis translate_off region); USED_BAUD_RATE selected accordingly.
REQ-004 SHALL have port aclk  input  1  single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rxbyte_tvalid  output  1  received byte available.
REQ-008 SHALL have port rxbyte_tready  input  1  downstream accepts byte.
REQ-009 SHALL have port rxbyte_tdata  output  8  received byte, LSB first on line.
REQ-010 SHALL have port rxbyte_tkeep  output  1  constant 1 whenever tvalid high.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse, byte dropped because output held.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer (reset value 1) before any use; all timing below is relative to the synchronized signal rxd_s.
REQ-014 SHALL derive TICS_PER_BEAT = ACLK_FREQUENCY / USED_BAUD_RATE (integer division) and HALF_BEAT = TICS_PER_BEAT / 2; tic counter width $clog2(TICS_PER_BEAT).
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: on rxd_s == 0, load tic counter with HALF_BEAT-1, go to START.
REQ-017 START: when counter reaches 0, if rxd_s == 0 load TICS_PER_BEAT-1, bit index 0, go to DATA; else (glitch) go to IDLE, no output.
REQ-018 DATA: counter decrements each cycle; at 0 sample rxd_s into shift register bit position (index), reload TICS_PER_BEAT-1; after 8th sample go to STOP.
REQ-019 STOP: at counter 0 sample rxd_s; if 1, deliver byte (REQ-021) and go to IDLE; if 0, pulse frame_error, discard byte, go to BREAK.
REQ-020 BREAK: remain until rxd_s == 1, then IDLE; no start detection while in BREAK.
REQ-021 Delivery: rxbyte_tvalid and rxbyte_tdata update on the cycle after the stop-bit sample.
REQ-022 Once tvalid is high, tdata SHALL be stable until the cycle after tvalid && tready; tvalid then deasserts unless a new byte loads in that same cycle.
REQ-023 If a byte completes while tvalid high and tready low: old byte kept, new byte dropped, overrun pulses for one cycle.
REQ-024 If a byte completes in the same cycle as tvalid && tready: new byte loads, tvalid stays high, no overrun.
REQ-025 Receiver SHALL never stall on tready; line reception continues regardless of downstream.
REQ-026 rxbyte_tkeep SHALL be driven 1'b1 constantly.

Reset
REQ-027 On aresetn low: state IDLE, rxbyte_tvalid 0, rxbyte_tdata 0, frame_error 0, overrun 0, synchronizer flops 1, counters 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output; after release, reception restarts on the next falling edge seen in IDLE.

Structure
REQ-029 State enum and a tics-per-beat function SHALL live in shared package axis_uart_pkg, usable by the transmitter too.
REQ-030 Synchronizer SHALL be sub-module uart_rx_sync (2 flops, parameterised reset value).

Verification (ACLK_FREQUENCY=100000000, BAUD_RATE_SIM=10000000, TICS_PER_BEAT=10)
REQ-031 Drive 0xA5 frame 8N1, tready=1 -> one tvalid beat, tdata=0xA5, tkeep=1, no error pulses.
REQ-032 Two back-to-back frames 0x00, 0xFF with tready=0 until after second stop bit -> tdata=0x00 retained, overrun pulses once, 0xFF never presented.
REQ-033 0x3C frame with stop bit low, then line high -> frame_error pulses once, no tvalid; following 0x81 frame received correctly.
REQ-034 Low glitch of 3 cycles on idle line -> return to IDLE, no tvalid, no error.
REQ-035 aresetn low during bit 4 of 0x55, released, then 0x5A frame -> only 0x5A delivered.
REQ-036 Loopback with axis_uart_tx, 16 random bytes, random tready -> byte-exact sequence, no frame_error.
